// File: rtl/led_sequencer_pkg.sv
// Shared types and constants for the LED pattern sequencer: FSM encoding,
// mode selectors and the power-on bounce pattern.
package led_seq_pkg;

  localparam int SEQ_NUM_LEDS = 8;
  localparam int SEQ_DEPTH    = 16;
  localparam int SEQ_IDX_W    = 4;
  localparam int SEQ_DIV_W    = 24;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  localparam logic MODE_LOOP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Entry 0 is the least significant byte; the sweep goes out to LED7 and back.
  localparam logic [16*8-1:0] DEFAULT_TABLE = {
    8'h01, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  function automatic logic [7:0] default_pattern(input int i);
    return DEFAULT_TABLE[(i % 16)*8 +: 8];
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Pattern-table configuration port between board control logic and the sequencer.
// A write transfers on a clock edge where cfg_we && cfg_ready; nothing is queued otherwise.
interface led_sequencer_if #(
  parameter int IDX_W    = 4,
  parameter int NUM_LEDS = 8
) ();
  logic                cfg_we;
  logic [IDX_W-1:0]    cfg_addr;
  logic [NUM_LEDS-1:0] cfg_data;
  logic                cfg_ready;

  modport master (output cfg_we, output cfg_addr, output cfg_data, input cfg_ready);
  modport slave  (input cfg_we, input cfg_addr, input cfg_data, output cfg_ready);
endinterface

// File: rtl/led_sequencer_prescaler.sv
// Step-rate prescaler: latches the divider on load (0 means 1) and pulses
// o_tick on the last cycle of each step while enabled.
module led_seq_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_div_eff;
  logic [DIV_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == (r_div_eff - DIV_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_div_eff <= DIV_W'(1);
    end else if (i_load) begin
      r_cnt     <= '0;
      r_div_eff <= (i_div == '0) ? DIV_W'(1) : i_div;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end
endmodule

// File: rtl/led_sequencer.sv
// Programmable LED pattern scheduler: 16-entry table stepped at a prescaled
// rate in loop or one-shot mode, with start/stop control.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS = SEQ_NUM_LEDS,
  parameter int DEPTH    = SEQ_DEPTH,
  parameter int IDX_W    = SEQ_IDX_W,
  parameter int DIV_W    = SEQ_DIV_W
) (
  input  logic                clk,
  input  logic                rst_n,
  led_sequencer_if.slave      cfg,
  input  logic [IDX_W-1:0]    i_len,
  input  logic [DIV_W-1:0]    i_div,
  input  logic                i_mode,
  input  logic                i_start,
  input  logic                i_stop,
  output logic [NUM_LEDS-1:0] o_leds,
  output logic                o_busy,
  output logic                o_done,
  output logic [IDX_W-1:0]    o_step_idx,
  output state_e              o_state
);
  logic [1:0]          r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_len;
  logic                r_mode;
  logic [NUM_LEDS-1:0] r_leds;
  logic                r_busy;
  logic                r_done;
  logic [NUM_LEDS-1:0] r_table [DEPTH];

  logic                w_tick;
  logic                w_start;
  logic                w_last;
  logic                w_cfg_accept;
  logic [IDX_W-1:0]    w_next_idx;

  assign w_start      = i_start && !i_stop;
  assign w_last       = (r_idx == r_len);
  assign w_next_idx   = r_idx + 1'b1;
  assign cfg.cfg_ready = (r_state != ST_RUN);
  assign w_cfg_accept = cfg.cfg_we && (r_state != ST_RUN);

  led_seq_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_start),
    .i_clear (i_stop),
    .i_en    (r_state == ST_RUN),
    .i_div   (i_div),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= NUM_LEDS'(default_pattern(i));
    end else if (w_cfg_accept) begin
      r_table[cfg.cfg_addr] <= cfg.cfg_data;
    end
  end

  // stop outranks start; start from any state (re)enters RUN at entry 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_mode  <= MODE_LOOP;
      r_leds  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_stop) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_leds  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_start) begin
      r_state <= ST_RUN;
      r_idx   <= '0;
      r_len   <= i_len;
      r_mode  <= i_mode;
      r_leds  <= r_table[0];
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if ((r_state == ST_RUN) && w_tick) begin
      if (!w_last) begin
        r_idx  <= w_next_idx;
        r_leds <= r_table[w_next_idx];
      end else if (r_mode == MODE_LOOP) begin
        r_idx  <= '0;
        r_leds <= r_table[0];
      end else begin
        r_state <= ST_DONE;
        r_busy  <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign o_leds     = r_leds;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_step_idx = r_idx;
  assign o_state    = state_e'(r_state);
endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: fixed vectors against the default
// table, hand-written corner sequences, and randomized runs against a step model.
module tb_led_sequencer;
  import led_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  len;
  logic [23:0] div;
  logic        mode, start, stop;
  logic [7:0]  leds;
  logic        busy, done;
  logic [3:0]  step_idx;
  state_e      state;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] m_table [16];

  always #5 clk = ~clk;

  led_sequencer_if #(.IDX_W(4), .NUM_LEDS(8)) cfg_bus ();

  led_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (cfg_bus),
    .i_len      (len),
    .i_div      (div),
    .i_mode     (mode),
    .i_start    (start),
    .i_stop     (stop),
    .o_leds     (leds),
    .o_busy     (busy),
    .o_done     (done),
    .o_step_idx (step_idx),
    .o_state    (state)
  );

  typedef struct {
    logic [3:0]  len;
    logic [23:0] div;
    logic        mode;
    int          j;
    logic [7:0]  exp_leds;
    logic        exp_busy;
    logic        exp_done;
    logic [3:0]  exp_idx;
  } vec_t;

  vec_t vecs [16];

  task automatic init_model();
    m_table = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h01};
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] l, input logic [23:0] d, input logic m);
    len = l; div = d; mode = m; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = a; cfg_bus.cfg_data = d;
    step();
    cfg_bus.cfg_we = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".leds"}, leds, 8'h00);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".done"}, done, 1'b0);
    check({tag, ".idx"}, step_idx, 4'd0);
    check({tag, ".ready"}, cfg_bus.cfg_ready, 1'b1);
    check({tag, ".state"}, state, IDLE);
  endtask

  // j = clock edges since the edge that sampled start; entry = floor(j / div_eff).
  task automatic check_model(input string tag, input int j, input int l, input int de, input bit m);
    int s, idx;
    bit fin;
    s = j / de;
    if (m == MODE_LOOP) begin idx = s % (l + 1); fin = 1'b0; end
    else if (s <= l) begin idx = s; fin = 1'b0; end
    else begin idx = l; fin = 1'b1; end
    check({tag, ".leds"}, leds, m_table[idx]);
    check({tag, ".busy"}, busy, !fin);
    check({tag, ".done"}, done, fin);
    check({tag, ".idx"}, step_idx, idx);
    check({tag, ".ready"}, cfg_bus.cfg_ready, fin);
  endtask

  initial begin
    rst_n = 1'b0; len = '0; div = '0; mode = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_data = '0;
    init_model();
    step(); step();
    rst_n = 1'b1;
    step();
    check_idle("reset");

    vecs[0]  = '{4'd13, 24'd4, 1'b0, 0,  8'h01, 1'b1, 1'b0, 4'd0};
    vecs[1]  = '{4'd13, 24'd4, 1'b0, 3,  8'h01, 1'b1, 1'b0, 4'd0};
    vecs[2]  = '{4'd13, 24'd4, 1'b0, 4,  8'h02, 1'b1, 1'b0, 4'd1};
    vecs[3]  = '{4'd13, 24'd4, 1'b0, 55, 8'h02, 1'b1, 1'b0, 4'd13};
    vecs[4]  = '{4'd13, 24'd4, 1'b0, 56, 8'h01, 1'b1, 1'b0, 4'd0};
    vecs[5]  = '{4'd2,  24'd3, 1'b1, 3,  8'h02, 1'b1, 1'b0, 4'd1};
    vecs[6]  = '{4'd2,  24'd3, 1'b1, 8,  8'h04, 1'b1, 1'b0, 4'd2};
    vecs[7]  = '{4'd2,  24'd3, 1'b1, 9,  8'h04, 1'b0, 1'b1, 4'd2};
    vecs[8]  = '{4'd2,  24'd3, 1'b1, 20, 8'h04, 1'b0, 1'b1, 4'd2};
    vecs[9]  = '{4'd0,  24'd0, 1'b1, 0,  8'h01, 1'b1, 1'b0, 4'd0};
    vecs[10] = '{4'd0,  24'd0, 1'b1, 1,  8'h01, 1'b0, 1'b1, 4'd0};
    vecs[11] = '{4'd0,  24'd2, 1'b0, 7,  8'h01, 1'b1, 1'b0, 4'd0};
    vecs[12] = '{4'd15, 24'd1, 1'b0, 7,  8'h80, 1'b1, 1'b0, 4'd7};
    vecs[13] = '{4'd15, 24'd1, 1'b0, 15, 8'h01, 1'b1, 1'b0, 4'd15};
    vecs[14] = '{4'd15, 24'd1, 1'b0, 17, 8'h02, 1'b1, 1'b0, 4'd1};
    vecs[15] = '{4'd15, 24'd1, 1'b1, 16, 8'h01, 1'b0, 1'b1, 4'd15};

    for (int v = 0; v < 16; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      pulse_stop();
      pulse_start(vecs[v].len, vecs[v].div, vecs[v].mode);
      repeat (vecs[v].j) step();
      check({tag, ".leds"}, leds, vecs[v].exp_leds);
      check({tag, ".busy"}, busy, vecs[v].exp_busy);
      check({tag, ".done"}, done, vecs[v].exp_done);
      check({tag, ".idx"}, step_idx, vecs[v].exp_idx);
    end

    // Config writes in IDLE are taken; the one attempted during RUN is dropped.
    pulse_stop();
    check("cfg.ready_idle", cfg_bus.cfg_ready, 1'b1);
    cfg_write(4'd0, 8'hAA); m_table[0] = 8'hAA;
    cfg_write(4'd1, 8'h55); m_table[1] = 8'h55;
    pulse_start(4'd1, 24'd1, MODE_LOOP);
    check_model("alt.j0", 0, 1, 1, 1'b0);
    cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = 4'd0; cfg_bus.cfg_data = 8'hFF;
    check("cfg.ready_run", cfg_bus.cfg_ready, 1'b0);
    step();
    cfg_bus.cfg_we = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      check_model($sformatf("alt.j%0d", j), j, 1, 1, 1'b0);
      step();
    end
    pulse_stop();
    pulse_start(4'd1, 24'd1, MODE_LOOP);
    check("alt.not_queued", leds, 8'hAA);

    // Write in DONE lands in the table but leds hold until restart.
    pulse_stop();
    pulse_start(4'd0, 24'd1, MODE_ONESHOT);
    step();
    check("donewr.done", done, 1'b1);
    cfg_write(4'd0, 8'h33); m_table[0] = 8'h33;
    check("donewr.hold", leds, 8'hAA);
    step();
    check("donewr.hold2", leds, 8'hAA);
    pulse_start(4'd0, 24'd1, MODE_ONESHOT);
    check("donewr.restart", leds, 8'h33);

    // stop in DONE
    step();
    pulse_stop();
    check_idle("stop_done");

    // start and stop together while running: stop wins
    pulse_start(4'd13, 24'd4, MODE_LOOP);
    step();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check_idle("startstop");
    step();
    check_idle("startstop2");

    // restart mid-step resets index and prescaler
    pulse_start(4'd13, 24'd4, MODE_LOOP);
    repeat (6) step();
    check_model("mid.pre", 6, 13, 4, 1'b0);
    pulse_start(4'd3, 24'd2, MODE_LOOP);
    for (int j = 0; j <= 9; j++) begin
      check_model($sformatf("mid.j%0d", j), j, 3, 2, 1'b0);
      step();
    end

    for (int it = 0; it < 20; it++) begin
      int l, d, de, total, nw;
      bit m;
      pulse_stop();
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        logic [3:0] a;
        logic [7:0] dt;
        a = 4'($urandom_range(0, 15));
        dt = 8'($urandom_range(0, 255));
        cfg_write(a, dt);
        m_table[a] = dt;
      end
      l = $urandom_range(0, 15);
      d = $urandom_range(0, 4);
      m = 1'($urandom_range(0, 1));
      de = (d == 0) ? 1 : d;
      total = (l + 1) * de + $urandom_range(0, 6);
      pulse_start(4'(l), 24'(d), m);
      for (int j = 0; j <= total; j++) begin
        check_model($sformatf("rnd%0d.j%0d", it, j), j, l, de, m);
        if ((m == MODE_LOOP || (j / de) <= l) && $urandom_range(0, 4) == 0) begin
          cfg_bus.cfg_we = 1'b1;
          cfg_bus.cfg_addr = 4'($urandom_range(0, 15));
          cfg_bus.cfg_data = 8'($urandom_range(0, 255));
        end
        step();
        cfg_bus.cfg_we = 1'b0;
      end
    end

    // asynchronous reset between edges while running
    pulse_stop();
    pulse_start(4'd5, 24'd2, MODE_LOOP);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    init_model();
    step();
    check_idle("after_rst");
    pulse_start(4'd1, 24'd1, MODE_LOOP);
    check("after_rst.e0", leds, 8'h01);
    step();
    check("after_rst.e1", leds, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
